// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared constants, serializer state encoding and a counter
//                width helper for the FIR output serializer slice.
//  Contents    : DATA_W      - sample width
//                SAMPLE_DIV  - clocks per 600 kHz sample at 12 MHz
//                DROP_CNT_W  - width of the dropped-sample counter
//                state_t     - serializer FSM states
//                cnt_w()     - counter width for a modulus, never below 1
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

   localparam int DATA_W     = 16;
   localparam int SAMPLE_DIV = 20;
   localparam int DROP_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } state_t;

   // A modulus of 1 still needs a 1-bit counter so vectors never collapse to zero width.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_out_serializer_if
//  Description : FIR output sample interface plus serial link / status.
//  Signals     : iFirOut        - signed FIR sample
//                iEnSample_600k - sample-rate enable
//                iEnDelay       - pipeline-valid enable
//                iOvfClr        - clears overflow flag and drop count
//                oSdata         - serial data, MSB first
//                oFrame         - high while a sample's bits are on oSdata
//                oBusy          - serializer not idle
//                oLevel         - FIFO occupancy
//                oOvf           - sticky overflow flag
//                oDropCnt       - saturating dropped-sample count
//  Modports    : master (sample producer / link observer), slave (serializer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_out_serializer_if #(
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int DEPTH  = 4
);
   import fir_pkg::*;

   logic [DATA_W-1:0]          iFirOut;
   logic                       iEnSample_600k;
   logic                       iEnDelay;
   logic                       iOvfClr;
   logic                       oSdata;
   logic                       oFrame;
   logic                       oBusy;
   logic [$clog2(DEPTH+1)-1:0] oLevel;
   logic                       oOvf;
   logic [DROP_CNT_W-1:0]      oDropCnt;

   modport master (
      output iFirOut, iEnSample_600k, iEnDelay, iOvfClr,
      input  oSdata, oFrame, oBusy, oLevel, oOvf, oDropCnt
   );

   modport slave (
      input  iFirOut, iEnSample_600k, iEnDelay, iOvfClr,
      output oSdata, oFrame, oBusy, oLevel, oOvf, oDropCnt
   );

endinterface
`default_nettype wire

// File: rtl/fir_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sample_fifo
//  Description : DEPTH x DATA_W show-ahead FIFO. Full/empty come from the
//                occupancy counter; pointers wrap modulo DEPTH (power of 2).
//                A push while full is accepted only if a pop happens the
//                same cycle.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                push, din      - write request and data
//                pop            - consume head (ignored when empty)
//                dout           - current head (valid when not empty)
//                level          - occupancy
//                full, empty    - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_fifo
   import fir_pkg::*;
#(
   parameter int DATA_W = fir_pkg::DATA_W,
   parameter int DEPTH  = 4
)(
   input  wire logic                       clk,
   input  wire logic                       rst,
   input  wire logic                       push,
   input  wire logic                       pop,
   input  wire logic [DATA_W-1:0]          din,
   output logic      [DATA_W-1:0]          dout,
   output logic      [$clog2(DEPTH+1)-1:0] level,
   output logic                            full,
   output logic                            empty
);

   localparam int PTR_W = cnt_w(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              w_do_push;
   logic              w_do_pop;

   assign empty     = (r_level == '0);
   assign full      = (r_level == LVL_W'(DEPTH));
   assign w_do_pop  = pop & ~empty;
   // When full, the slot being written is the one the pop frees this same edge.
   assign w_do_push = push & (~full | w_do_pop);

   assign dout  = r_mem[r_rd_ptr];
   assign level = r_level;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_out_serializer
//  Description : Captures FIR output samples when both enables are high,
//                buffers them in a small FIFO, and shifts them out MSB-first
//                on a framed serial link. Frame period at defaults is
//                LOAD(1) + SHIFT(16) + GAP(2) + IDLE(1) = 20 clocks, matching
//                the 600 kHz sample rate.
//  Ports       : iClk_12M - 12 MHz clock, rising edge
//                iRst     - synchronous active-high reset
//                bus      - fir_out_serializer_if.slave (samples in, link and
//                           status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_out_serializer
   import fir_pkg::*;
#(
   parameter int DATA_W     = fir_pkg::DATA_W,
   parameter int DEPTH      = 4,
   parameter int BIT_CYCLES = 1,
   parameter int GAP_CYCLES = 2
)(
   input wire logic            iClk_12M,
   input wire logic            iRst,
   fir_out_serializer_if.slave bus
);

   localparam int LVL_W = $clog2(DEPTH+1);
   localparam int BIT_W = cnt_w(DATA_W);
   localparam int CYC_W = cnt_w(BIT_CYCLES);
   localparam int GAP_W = cnt_w(GAP_CYCLES);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_W-1:0]     r_shreg;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [CYC_W-1:0]      r_cyc_cnt;
   logic [GAP_W-1:0]      r_gap_cnt;
   logic                  r_ovf;
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_drop;
   logic                  w_full;
   logic                  w_empty;
   logic [DATA_W-1:0]     w_head;
   logic [LVL_W-1:0]      w_level;
   logic                  w_frame;
   logic                  w_sdata;
   logic                  w_cyc_last;
   logic                  w_bit_last;
   logic                  w_gap_last;

   // ------------------------------------------------------------------
   // Capture qualification and buffering
   // ------------------------------------------------------------------
   assign w_push = bus.iEnSample_600k & bus.iEnDelay;
   assign w_drop = w_push & w_full & ~w_pop;

   fir_sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (iClk_12M),
      .rst   (iRst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (bus.iFirOut),
      .dout  (w_head),
      .level (w_level),
      .full  (w_full),
      .empty (w_empty)
   );

   // ------------------------------------------------------------------
   // Overflow flag and saturating drop counter; a drop outranks a clear
   // in the same cycle so no loss is ever hidden.
   // ------------------------------------------------------------------
   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
         if (bus.iOvfClr) begin
            r_drop_cnt <= DROP_CNT_W'(1);
         end else if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
         end
      end else if (bus.iOvfClr) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

   // ------------------------------------------------------------------
   // Serializer FSM
   // ------------------------------------------------------------------
   assign w_cyc_last = (r_cyc_cnt == CYC_W'(BIT_CYCLES-1));
   assign w_bit_last = (r_bit_cnt == BIT_W'(DATA_W-1));
   assign w_gap_last = (r_gap_cnt == GAP_W'(GAP_CYCLES-1));

   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_frame     = 1'b0;
      w_sdata     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            // Only reachable with a non-empty FIFO: nothing else drains it.
            w_pop       = 1'b1;
            w_state_nxt = SHIFT;
         end
         SHIFT: begin
            w_frame = 1'b1;
            w_sdata = r_shreg[DATA_W-1];
            if (w_cyc_last && w_bit_last) begin
               w_state_nxt = GAP;
            end
         end
         GAP: begin
            if (w_gap_last) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Shift register and bit / hold / gap counters
   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_cyc_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_shreg   <= w_head;
               r_bit_cnt <= '0;
               r_cyc_cnt <= '0;
               r_gap_cnt <= '0;
            end
            SHIFT: begin
               if (w_cyc_last) begin
                  r_cyc_cnt <= '0;
                  r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + BIT_W'(1);
               end else begin
                  r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
               end
            end
            GAP: begin
               r_gap_cnt <= w_gap_last ? '0 : r_gap_cnt + GAP_W'(1);
            end
            default: begin
               r_gap_cnt <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.oSdata   = w_sdata;
   assign bus.oFrame   = w_frame;
   assign bus.oBusy    = (r_state != IDLE);
   assign bus.oLevel   = w_level;
   assign bus.oOvf     = r_ovf;
   assign bus.oDropCnt = r_drop_cnt;

endmodule
`default_nettype wire
